// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port video RAM between the display scanout fetch and the
// host port. At most one access is issued per clock. The display wins every
// contended cycle, except that a host which has waited STARVE_LIMIT
// consecutive cycles wins the next contended arbitration. Read data is routed
// back to whichever requester issued the read, in issue order.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   disp_req/addr       display read request (held until disp_gnt)
//   disp_gnt            display request accepted this cycle (combinational)
//   disp_rvalid/rdata   display read return
//   host_req/we/addr/wdata  host request (held until host_gnt)
//   host_gnt            host request accepted this cycle (combinational)
//   host_rvalid/rdata   host read return (reads only)
//   mem_en/we/addr/wdata    registered memory access, one cycle after grant
//   mem_rdata           memory read data, RD_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        OWNER_DISP = 1'b0,
        OWNER_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    logic [CNT_W-1:0] starve_cnt;
    logic             host_wins;
    tag_t             tag_pipe [0:RD_LAT];

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        disp_gnt  = 1'b0;
        host_gnt  = 1'b0;
        host_wins = (starve_cnt == CNT_W'(STARVE_LIMIT));
        if (!rst) begin
            if (disp_req && host_req) begin
                host_gnt = host_wins;
                disp_gnt = !host_wins;
            end else begin
                disp_gnt = disp_req;
                host_gnt = host_req;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles the host waits while
    // requesting; any cycle without a pending host request restarts it.
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || !host_req || host_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Issue stage: registered memory strobe. Address and write data hold their
    // last values in idle cycles; display grants never touch mem_wdata.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= disp_gnt || host_gnt;
            mem_we <= host_gnt && host_we;
            if (host_gnt) begin
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
            end else if (disp_gnt) begin
                mem_addr  <= disp_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read tag pipeline. Entry 0 is loaded on the same edge as mem_en, so it
    // describes the access currently on the memory bus (valid = read issued).
    // Entry k then tracks that read k cycles later; entry RD_LAT lines up with
    // the cycle in which mem_rdata is valid for it.
    // -------------------------------------------------------------------------
    // NOTE: the tag pipeline is control state, so it is reset (dropping
    // in-flight reads); the data path registers below only need their
    // visible outputs cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: disp_gnt || (host_gnt && !host_we),
                             owner: host_gnt ? OWNER_HOST : OWNER_DISP};
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read return: register mem_rdata into the owner's port. The non-owner's
    // data register holds.
    // -------------------------------------------------------------------------
    logic ret_disp;
    logic ret_host;

    assign ret_disp = tag_pipe[RD_LAT].valid && (tag_pipe[RD_LAT].owner == OWNER_DISP);
    assign ret_host = tag_pipe[RD_LAT].valid && (tag_pipe[RD_LAT].owner == OWNER_HOST);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            disp_rvalid <= ret_disp;
            host_rvalid <= ret_host;
            if (ret_disp) begin
                disp_rdata <= mem_rdata;
            end
            if (ret_host) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed self-checking bench for vram_arbiter with RD_LAT=2 and
// STARVE_LIMIT=8. A behavioural VRAM model answers reads two cycles after
// mem_en; unwritten words read back as (addr[15:0] ^ 16'hA5A5).
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 16;
    localparam int RD_LAT       = 2;
    localparam int STARVE_LIMIT = 8;

    logic              clk;
    logic              rst;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    vram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RD_LAT      (RD_LAT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_rvalid(disp_rvalid),
        .disp_rdata (disp_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int we_cnt   = 0;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t disp_rv_q [$];
    ret_t host_rv_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // -------------------------------------------------------------------------
    // Clock, cycle counter, VRAM model (RD_LAT = 2 stage read pipe)
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] vmem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] rd_p1 = '0;
    logic [DATA_W-1:0] rd_p2 = '0;
    assign mem_rdata = rd_p2;

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            vmem[mem_addr] = mem_wdata;
        end
        if (mem_en && !mem_we) begin
            rd_p1 <= vmem.exists(mem_addr) ? vmem[mem_addr] : init_val(mem_addr);
        end
        rd_p2 <= rd_p1;
    end

    // -------------------------------------------------------------------------
    // Monitor: log returns, count writes, check mutual exclusion
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (disp_rvalid) disp_rv_q.push_back('{cyc, disp_rdata});
        if (host_rvalid) host_rv_q.push_back('{cyc, host_rdata});
        if (mem_en && mem_we) we_cnt++;
        if (disp_rvalid || host_rvalid) check("rvalid_excl", 32'(disp_rvalid && host_rvalid), 0);
        if (disp_gnt || host_gnt) check("gnt_excl", 32'(disp_gnt && host_gnt), 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant on the chosen port, return its cycle, advance one cycle.
    task automatic wait_gnt(input bit host, output int g);
        g = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (host ? host_gnt : disp_gnt) begin
                g = cyc;
                tick();
                return;
            end
            tick();
        end
        check(host ? "host_gnt_timeout" : "disp_gnt_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        disp_rv_q.delete();
        host_rv_q.delete();
        we_cnt = 0;
    endtask

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    int k, g0, g_wr, g_rd, r_host, budget;
    logic              prev_g;
    logic [ADDR_W-1:0] prev_a;
    int                il_gnt [16];

    initial begin
        rst        = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;

        // ---- Reset state ----
        repeat (2) tick();
        @(negedge clk);
        check("rst_mem_en",      32'(mem_en), 0);
        check("rst_mem_we",      32'(mem_we), 0);
        check("rst_mem_addr",    32'(mem_addr), 0);
        check("rst_mem_wdata",   32'(mem_wdata), 0);
        check("rst_disp_rvalid", 32'(disp_rvalid), 0);
        check("rst_host_rvalid", 32'(host_rvalid), 0);
        check("rst_disp_rdata",  32'(disp_rdata), 0);
        check("rst_host_rdata",  32'(host_rdata), 0);
        tick();
        rst = 1'b0;
        tick();

        // ---- Display-only stream, addresses 0..F ----
        clear_logs();
        disp_req  = 1'b1;
        disp_addr = '0;
        k = 0; g0 = -1; budget = 0;
        prev_g = 1'b0; prev_a = '0;
        while (k < 16 && budget < 40) begin
            @(negedge clk);
            check("ds_mem_en", 32'(mem_en), 32'(prev_g));
            if (prev_g) check("ds_mem_addr", 32'(mem_addr), 32'(prev_a));
            prev_g = disp_gnt;
            prev_a = disp_addr;
            if (disp_gnt) begin
                if (k == 0) g0 = cyc;
                k++;
            end
            budget++;
            tick();
            disp_addr = ADDR_W'(k);
            if (k == 16) disp_req = 1'b0;
        end
        check("ds_grants", 32'(k), 16);
        check("ds_budget", 32'(budget), 16);
        @(negedge clk);
        check("ds_last_en",   32'(mem_en), 1);
        check("ds_last_addr", 32'(mem_addr), 32'h0000F);
        tick();
        @(negedge clk);
        check("ds_idle_en",   32'(mem_en), 0);
        check("ds_idle_we",   32'(mem_we), 0);
        check("ds_hold_addr", 32'(mem_addr), 32'h0000F);
        repeat (6) tick();
        check("ds_rv_count", 32'(disp_rv_q.size()), 16);
        check("ds_host_rv",  32'(host_rv_q.size()), 0);
        for (int i = 0; i < 16 && i < disp_rv_q.size(); i++) begin
            check("ds_rv_cycle", 32'(disp_rv_q[i].cyc - g0), 32'(i + 4));
            check("ds_rv_data",  32'(disp_rv_q[i].data), 32'(init_val(ADDR_W'(i))));
        end

        // ---- Host write 0xF800 @ 0x12345, then read it back ----
        clear_logs();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 17'h12345;
        host_wdata = 16'hF800;
        wait_gnt(1'b1, g_wr);
        host_we = 1'b0;
        wait_gnt(1'b1, g_rd);
        host_req = 1'b0;
        repeat (8) tick();
        check("hw_we_cycles", 32'(we_cnt), 1);
        check("hw_rd_after_wr", 32'(g_rd - g_wr), 1);
        check("hw_rv_count", 32'(host_rv_q.size()), 1);
        if (host_rv_q.size() > 0) begin
            check("hw_rv_data",  32'(host_rv_q[0].data), 32'hF800);
            check("hw_rv_cycle", 32'(host_rv_q[0].cyc - g_rd), 4);
        end
        check("hw_disp_rv", 32'(disp_rv_q.size()), 0);

        // ---- Contention: display wins 8, host wins the 9th, repeating ----
        clear_logs();
        disp_req  = 1'b1;
        disp_addr = 17'h00100;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 17'h00200;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            check("ct_host_gnt", 32'(host_gnt), 32'(i % 9 == 8));
            check("ct_disp_gnt", 32'(disp_gnt), 32'(i % 9 != 8));
            tick();
        end
        disp_req = 1'b0;
        host_req = 1'b0;
        repeat (6) tick();
        check("ct_host_rv", 32'(host_rv_q.size()), 3);
        check("ct_disp_rv", 32'(disp_rv_q.size()), 24);
        if (host_rv_q.size() > 0) check("ct_host_data", 32'(host_rv_q[0].data), 32'hA7A5);
        if (disp_rv_q.size() > 0) check("ct_disp_data", 32'(disp_rv_q[0].data), 32'hA4A5);

        // ---- Interleaved display/host reads every cycle ----
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                disp_req  = 1'b1;
                host_req  = 1'b0;
                disp_addr = ADDR_W'(17'h00300 + i / 2);
            end else begin
                disp_req  = 1'b0;
                host_req  = 1'b1;
                host_we   = 1'b0;
                host_addr = ADDR_W'(17'h00400 + i / 2);
            end
            @(negedge clk);
            check("il_gnt", 32'((i % 2 == 1) ? host_gnt : disp_gnt), 1);
            il_gnt[i] = cyc;
            tick();
        end
        disp_req = 1'b0;
        host_req = 1'b0;
        repeat (6) tick();
        check("il_disp_count", 32'(disp_rv_q.size()), 8);
        check("il_host_count", 32'(host_rv_q.size()), 8);
        for (int j = 0; j < 8 && j < disp_rv_q.size(); j++) begin
            check("il_disp_cycle", 32'(disp_rv_q[j].cyc - il_gnt[2*j]), 4);
            check("il_disp_data",  32'(disp_rv_q[j].data), 32'(init_val(ADDR_W'(17'h00300 + j))));
        end
        for (int j = 0; j < 8 && j < host_rv_q.size(); j++) begin
            check("il_host_cycle", 32'(host_rv_q[j].cyc - il_gnt[2*j+1]), 4);
            check("il_host_data",  32'(host_rv_q[j].data), 32'(init_val(ADDR_W'(17'h00400 + j))));
        end

        // ---- Reset one cycle after a host read grant ----
        clear_logs();
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 17'h00500;
        @(negedge clk);
        check("mr_host_gnt", 32'(host_gnt), 1);
        tick();
        rst       = 1'b1;
        disp_req  = 1'b1;
        disp_addr = 17'h00700;
        host_addr = 17'h00600;
        @(negedge clk);
        check("mr_gnt_supp_d", 32'(disp_gnt), 0);
        check("mr_gnt_supp_h", 32'(host_gnt), 0);
        tick();
        @(negedge clk);
        check("mr_mem_en",      32'(mem_en), 0);
        check("mr_mem_addr",    32'(mem_addr), 0);
        check("mr_mem_wdata",   32'(mem_wdata), 0);
        check("mr_host_rvalid", 32'(host_rvalid), 0);
        check("mr_host_rdata",  32'(host_rdata), 0);
        check("mr_disp_rdata",  32'(disp_rdata), 0);
        check("mr_gnt_supp_d2", 32'(disp_gnt), 0);
        tick();
        rst = 1'b0;
        r_host = -1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("mr_post_host_gnt", 32'(host_gnt), 32'(i == 8));
            check("mr_post_disp_gnt", 32'(disp_gnt), 32'(i != 8));
            if (host_gnt) r_host = cyc;
            tick();
        end
        disp_req = 1'b0;
        host_req = 1'b0;
        repeat (6) tick();
        check("mr_host_rv_count", 32'(host_rv_q.size()), 1);
        if (host_rv_q.size() > 0) begin
            check("mr_host_rv_cycle", 32'(host_rv_q[0].cyc - r_host), 4);
            check("mr_host_rv_data",  32'(host_rv_q[0].data), 32'hA3A5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM between two requesters:
  - the display scanout fetch, which has a hard real-time deadline;
  - the host port, which performs writes and readback.
- Issues at most one memory access per clock.
- Routes read data back to the requester that issued the read.
- Display has fixed priority; a starvation guard guarantees host forward progress.

Parameters:
ADDR_W, 17, VRAM word address width
DATA_W, 16, VRAM word width (RGB565 pixel)
RD_LAT, 2, cycles from mem_en sample to valid mem_rdata (>=1)
STARVE_LIMIT, 8, consecutive host wait cycles after which host wins one arbitration (>=1)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-high
disp_req  in  1  display read request; held until disp_gnt
disp_addr  in  ADDR_W  display read address; stable while disp_req
disp_gnt  out  1  display request accepted this cycle
disp_rvalid  out  1  disp_rdata valid
disp_rdata  out  DATA_W  display read data
host_req  in  1  host request; held until host_gnt
host_we  in  1  1=write, 0=read; stable while host_req
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host request accepted this cycle
host_rvalid  out  1  host_rdata valid (reads only)
host_rdata  out  DATA_W  host read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after mem_en

Behaviour:

Reset:
- One clock, clk.
- rst is synchronous and active-high.
- While rst is high: all registered outputs go to 0 (mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, disp_rdata, host_rvalid, host_rdata). The starvation counter and the read-tag pipeline are cleared.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them.

Arbitration (combinational, per cycle):
- Neither requester: no grant.
- Only one requester: that requester is granted.
- Both requesters: display is granted, unless starve_cnt == STARVE_LIMIT, in which case host is granted.
- disp_gnt and host_gnt are never both high.
- Grants are suppressed while rst is high.
- A requester may present its next request in the cycle after its grant; back-to-back grants to the same requester are allowed (one per cycle).

Issue:
- A grant in cycle N drives mem_en=1 in cycle N+1, with the granted addr/we/wdata registered.
- Display accesses always have mem_we=0.
- With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.

Starvation counter:
- Width is clog2(STARVE_LIMIT+1).
- Increments, saturating at STARVE_LIMIT, in any cycle where host_req=1 and host_gnt=0.
- Clears to 0 on host_gnt.
- Clears to 0 on any cycle where host_req=0.

Read return:
- The tag shift register is RD_LAT+1 deep, with entries {valid, owner}.
- An entry is pushed when mem_en=1 and mem_we=0.
- A read issued with mem_en in cycle M returns in cycle M+RD_LAT+1:
  - the owner's rvalid=1 for exactly one cycle;
  - the owner's rdata = mem_rdata sampled in cycle M+RD_LAT (registered).
- Returns arrive in issue order.
- The non-owner's rvalid stays 0; its rdata holds its last value.
- Host writes produce no rvalid.

Latency:
- Grant to mem_en: 1 cycle.
- Grant to rvalid: RD_LAT+2 cycles.
- Sustained throughput: 1 access per cycle.

Test Plan:
- Reset: after rst=1 for 2 cycles, with reads in flight -> mem_en=0; no rvalid for any in-flight read; all outputs 0.
- Display-only stream: disp_req held high, address increments 0x00000..0x0000F after each gnt -> 16 consecutive mem_en cycles at addrs 0..F; disp_rvalid high for 16 consecutive cycles starting 4 cycles after the first grant (RD_LAT=2); data matches memory model.
- Host write then read: write 0xF800 at 0x12345, then read 0x12345 -> mem_we=1 for exactly one cycle; host_rvalid exactly once with host_rdata=0xF800; disp_rvalid stays 0.
- Contention/starvation: disp_req and host_req held continuously with STARVE_LIMIT=8 -> display granted 8 cycles; host granted on the 9th cycle; display resumes; the pattern repeats every 9 cycles.
- Interleaved read returns: alternating display/host reads every cycle -> rvalid appears on the correct port, in issue order, with correct data; never both rvalid in the same cycle.
- Mid-burst reset: rst asserted one cycle after a host read grant -> no host_rvalid for that read; first post-reset grant behaves as from clean state (starve_cnt=0).
